// File: rtl/cache_line_mover.sv
// cache_line_mover: moves one cache line between the data RAM and the memory side (refill or writeback).
// Optional macro CACHE_LINE_MOVER_CRITICAL_FIRST_EN: a refill starts at the requested beat and wraps.
module cache_line_mover #(
  parameter int DATA_WIDTH = 256,
  parameter int BEATS      = 4,
  parameter int LINE_IDX_W = 7,
  localparam int BEAT_W    = $clog2(BEATS),
  localparam int BANK_W    = LINE_IDX_W + BEAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [LINE_IDX_W-1:0] req_line,
  input  logic [BEAT_W-1:0]     req_beat,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wdata_last,
  output logic                  mc_en,
  output logic                  mc_rw,
  output logic [BANK_W-1:0]     mc_bank_index,
  output logic [DATA_WIDTH-1:0] mc_din,
  input  logic [DATA_WIDTH-1:0] mc_dout,
  output logic                  done
);

  localparam logic [BEAT_W:0] BEATS_N = (BEAT_W+1)'(BEATS);
  localparam logic [BEAT_W:0] LAST_N  = (BEAT_W+1)'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WB, DONE} state_t;
  state_t state, state_nxt;

  logic [LINE_IDX_W-1:0] line_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BEAT_W:0]       num_cnt;
  logic [BEAT_W-1:0]     sent_cnt;
  logic [BEAT_W-1:0]     refill_start;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;
  logic [2:0]            fifo_resv;
  logic                  accept, rf_beat, rd_issue, wdata_vld, wb_pop;

`ifdef CACHE_LINE_MOVER_CRITICAL_FIRST_EN
  assign refill_start = req_beat;
`else
  assign refill_start = req_beat & '0;
`endif

  assign accept    = req_valid && (state == IDLE);
  assign rf_beat   = (state == REFILL) && mem_rdata_valid;
  assign wdata_vld = (state == WB) && (fifo_cnt != 2'd0);
  assign wb_pop    = wdata_vld && mem_wdata_ready;
  // Slots still claimed after this cycle's pop: entries kept plus the read returning now.
  assign fifo_resv = 3'(fifo_cnt) + 3'(rd_vld_p1) - 3'(wb_pop);
  assign rd_issue  = (state == WB) && (num_cnt < BEATS_N) && (fifo_resv < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = req_wb ? WB : REFILL;
      REFILL:  if (rf_beat && (num_cnt == LAST_N)) state_nxt = DONE;
      WB:      if (wb_pop && (sent_cnt == '1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = 1'b0;
    mem_rdata_ready = 1'b0;
    mc_en           = 1'b0;
    mc_rw           = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_wdata_last  = 1'b0;
    done            = 1'b0;
    unique case (state)
      IDLE:   req_ready = 1'b1;
      REFILL: begin
        mem_rdata_ready = 1'b1;
        mc_rw           = 1'b1;
        mc_en           = mem_rdata_valid;
      end
      WB: begin
        mc_en           = rd_issue;
        mem_wdata_valid = wdata_vld;
        mem_wdata_last  = wdata_vld && (sent_cnt == '1);
      end
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  assign mc_bank_index = {line_q, beat_cnt};
  assign mc_din        = mem_rdata;
  assign mem_wdata     = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q   <= '0;
      beat_cnt <= '0;
      num_cnt  <= '0;
      sent_cnt <= '0;
    end else if (accept) begin
      line_q   <= req_line;
      beat_cnt <= req_wb ? '0 : refill_start;
      num_cnt  <= '0;
      sent_cnt <= '0;
    end else begin
      if (rf_beat || rd_issue) begin
        beat_cnt <= beat_cnt + 1'b1;
        num_cnt  <= num_cnt + 1'b1;
      end
      if (wb_pop) sent_cnt <= sent_cnt + 1'b1;
    end
  end

  // p1: RAM read data returns one cycle after the read and lands in the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1 <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      rd_vld_p1 <= rd_issue;
      if (rd_vld_p1) wr_ptr <= ~wr_ptr;
      if (wb_pop)    rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, wb_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1) fifo_mem[wr_ptr] <= mc_dout;
  end

endmodule

// File: doc/cache_line_mover.md
CACHE_LINE_MOVER -- requirements
Module: cache_line_mover

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, giving the beat and RAM word width in bits.
REQ-002 SHALL have parameter BEATS, default 4 (power of two, >=2), giving the number of beats per cache line.
REQ-003 SHALL have parameter LINE_IDX_W, default 7, giving the line index width; BANK_W = LINE_IDX_W + log2(BEATS).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk input 1 is the clock, and rst input 1 is the reset.
REQ-005 SHALL have these request ports: req_valid input 1; req_ready output 1; req_wb input 1 (1=writeback from RAM, 0=refill into RAM); req_line input LINE_IDX_W; req_beat input log2(BEATS) (first beat, used only under the macro in REQ-021).
REQ-006 SHALL have these refill-in ports: mem_rdata_valid input 1; mem_rdata_ready output 1; mem_rdata input DATA_WIDTH.
REQ-007 SHALL have these writeback-out ports: mem_wdata_valid output 1; mem_wdata_ready input 1; mem_wdata output DATA_WIDTH; mem_wdata_last output 1.
REQ-008 SHALL have these data RAM memory-controller ports: mc_en output 1; mc_rw output 1 (1=write); mc_bank_index output BANK_W; mc_din output DATA_WIDTH; mc_dout input DATA_WIDTH.
REQ-009 SHALL have output done, width 1, a one-cycle completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, REFILL, WB, DONE; req_ready = (state==IDLE); a req_valid&req_ready handshake latches req_wb/req_line/req_beat and moves to WB if req_wb, else REFILL.
REQ-011 SHALL always form mc_bank_index as {latched line, beat counter}.
REQ-012 SHALL, in REFILL, drive mem_rdata_ready=1; each mem_rdata_valid&ready beat drives mc_en=1, mc_rw=1, mc_din=mem_rdata the same cycle (combinational, zero latency) and advances the beat counter; after BEATS beats the FSM moves to DONE.
REQ-013 SHALL treat the mc port as accepting a request every cycle (no ready input); in IDLE and DONE, mc_en=0, mem_rdata_ready=0.
REQ-014 SHALL, in WB, issue a RAM read (mc_en=1, mc_rw=0) when issued<BEATS and (buffer occupancy + reads in flight) < 2; mc_dout is captured into a 2-entry FIFO exactly one cycle after each read.
REQ-015 SHALL drive mem_wdata_valid = FIFO not empty and mem_wdata = FIFO head; mem_wdata_last=1 on the BEATS-th beat sent; the head pops on valid&ready.
REQ-016 SHALL move WB->DONE on the cycle the last beat handshakes; mem_wdata_valid may deassert at any time only when the FIFO is empty, and the head value SHALL be held stable while valid&~ready.
REQ-017 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-018 SHALL sustain one beat per cycle in both directions when the far side never stalls (writeback: first mem_wdata_valid 2 cycles after acceptance).

Reset
REQ-019 SHALL, while rst=1: state=IDLE, counters=0, FIFO empty, mc_en=0, mem_rdata_ready=0, mem_wdata_valid=0, mem_wdata_last=0, done=0, req_ready=1.
REQ-020 SHALL, when rst asserts mid-operation, abandon the transfer immediately, drop FIFO contents and in-flight reads, and issue no further mc_en.

Configuration
REQ-021 SHALL, with CACHE_LINE_MOVER_CRITICAL_FIRST_EN defined, start the refill beat counter at the latched req_beat and wrap modulo BEATS (BEATS beats total); without it, the refill starts at beat 0 and req_beat is ignored; writeback always starts at beat 0.

Verification
REQ-022 SHALL verify refill line 5: beats A,B,C,D back-to-back -> writes to bank 20,21,22,23 in consecutive cycles, done pulse 1 cycle after D.
REQ-023 SHALL verify writeback line 3 with mem_wdata_ready=1 -> reads of banks 12..15, four beats out, last on beat 4, done once.
REQ-024 SHALL verify writeback with ready low for 5 cycles after the first valid -> at most 2 reads outstanding, no beat lost or duplicated, head held stable.
REQ-025 SHALL verify, under the macro, refill line 1 with req_beat=2 -> bank order 6,7,4,5; without the macro -> 4,5,6,7.
REQ-026 SHALL verify rst asserted after 2 of 4 refill beats -> mc_en=0 immediately, req_ready=1, and a subsequent request completes normally.
REQ-027 SHALL verify req_valid held high during DONE -> accepted only in the following IDLE cycle, with no done overlap.
